// File: rtl/mc_control_unit_pkg.sv
// Shared constants and types for the multi-cycle control unit: opcodes, ALU and
// immediate codes, the 4-bit state encoding and the decoder's result record.
`timescale 1ns/1ps
package mc_control_unit_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b100000;
  localparam logic [5:0] OP_LI    = 6'b111000;
  localparam logic [5:0] OP_LUI   = 6'b111001;
  localparam logic [5:0] OP_ADDI  = 6'b110000;
  localparam logic [5:0] OP_ANDI  = 6'b110010;
  localparam logic [5:0] OP_ORI   = 6'b110011;
  localparam logic [5:0] OP_B     = 6'b111111;
  localparam logic [5:0] OP_BEQ   = 6'b000000;
  localparam logic [5:0] OP_BNE   = 6'b000001;
  localparam logic [5:0] OP_LB    = 6'b000011;
  localparam logic [5:0] OP_LW    = 6'b001111;
  localparam logic [5:0] OP_SB    = 6'b000111;
  localparam logic [5:0] OP_SW    = 6'b011111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;

  localparam logic [1:0] IMM_ZEXT     = 2'b00;
  localparam logic [1:0] IMM_SEXT     = 2'b01;
  localparam logic [1:0] IMM_HI16     = 2'b10;
  localparam logic [1:0] IMM_SEXT_SL2 = 2'b11;

  localparam logic [3:0] S_IF1   = 4'd0;
  localparam logic [3:0] S_IF2   = 4'd1;
  localparam logic [3:0] S_DEC   = 4'd2;
  localparam logic [3:0] S_EXR   = 4'd3;
  localparam logic [3:0] S_EXI   = 4'd4;
  localparam logic [3:0] S_BR    = 4'd5;
  localparam logic [3:0] S_MADDR = 4'd6;
  localparam logic [3:0] S_MRD   = 4'd7;
  localparam logic [3:0] S_MWR   = 4'd8;
  localparam logic [3:0] S_WBALU = 4'd9;
  localparam logic [3:0] S_WBMEM = 4'd10;

  typedef enum logic [2:0] {
    CLS_ALU_R,
    CLS_ALU_I,
    CLS_BRANCH,
    CLS_LOAD,
    CLS_STORE,
    CLS_ILLEGAL
  } instr_class_e;

  typedef enum logic [1:0] {
    BR_NONE,
    BR_ALWAYS,
    BR_EQ,
    BR_NE
  } br_kind_e;

  typedef struct packed {
    instr_class_e cls;
    br_kind_e     br;
    logic [3:0]   alu_func;
    logic [1:0]   imm_ext;
    logic         byte_op;
    logic         illegal;
  } dec_t;

  function automatic logic branch_taken(input br_kind_e br, input logic zero);
    case (br)
      BR_ALWAYS: return 1'b1;
      BR_EQ:     return zero;
      BR_NE:     return ~zero;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_control_unit_if.sv
// Bus between the control unit (master) and the datapath (slave): instruction and
// zero flag in, every datapath control strobe out.
`timescale 1ns/1ps
interface mc_control_unit_if;
  logic [31:0] Instr;
  logic        Zero;
  logic        PC_Sel;
  logic        PC_LdEn;
  logic        IR_LdEn;
  logic        RF_WrEn;
  logic        RF_WrData_sel;
  logic        RF_B_sel;
  logic        ALU_Bin_sel;
  logic [3:0]  ALU_func;
  logic [1:0]  ImmExt;
  logic        MEM_WrEn;
  logic        ByteOp;
  logic        Illegal;

  modport master (
    input  Instr, Zero,
    output PC_Sel, PC_LdEn, IR_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel,
           ALU_Bin_sel, ALU_func, ImmExt, MEM_WrEn, ByteOp, Illegal
  );

  modport slave (
    output Instr, Zero,
    input  PC_Sel, PC_LdEn, IR_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel,
           ALU_Bin_sel, ALU_func, ImmExt, MEM_WrEn, ByteOp, Illegal
  );
endinterface

// File: rtl/mc_control_unit_decoder.sv
// Combinational opcode classifier: instruction class, branch kind, ALU and
// immediate setup, byte access flag and illegal-opcode flag.
`timescale 1ns/1ps
module mc_decoder
  import mc_control_unit_pkg::*;
(
  input  logic [5:0] opcode,
  output dec_t       dec
);

  always_comb begin
    dec.cls      = CLS_ILLEGAL;
    dec.br       = BR_NONE;
    dec.alu_func = ALU_ADD;
    dec.imm_ext  = IMM_ZEXT;
    dec.byte_op  = 1'b0;
    dec.illegal  = 1'b0;
    case (opcode)
      OP_RTYPE: dec.cls = CLS_ALU_R;
      // li/lui add the immediate to r0, so they share addi's datapath
      OP_LI, OP_ADDI: begin
        dec.cls     = CLS_ALU_I;
        dec.imm_ext = IMM_SEXT;
      end
      OP_LUI: begin
        dec.cls     = CLS_ALU_I;
        dec.imm_ext = IMM_HI16;
      end
      OP_ANDI: begin
        dec.cls      = CLS_ALU_I;
        dec.alu_func = ALU_AND;
      end
      OP_ORI: begin
        dec.cls      = CLS_ALU_I;
        dec.alu_func = ALU_OR;
      end
      OP_B, OP_BEQ, OP_BNE: begin
        dec.cls      = CLS_BRANCH;
        dec.alu_func = ALU_SUB;
        dec.imm_ext  = IMM_SEXT_SL2;
        dec.br       = (opcode == OP_B)   ? BR_ALWAYS :
                       (opcode == OP_BEQ) ? BR_EQ : BR_NE;
      end
      OP_LB, OP_LW: begin
        dec.cls     = CLS_LOAD;
        dec.imm_ext = IMM_SEXT;
        dec.byte_op = (opcode == OP_LB);
      end
      OP_SB, OP_SW: begin
        dec.cls     = CLS_STORE;
        dec.imm_ext = IMM_SEXT;
        dec.byte_op = (opcode == OP_SB);
      end
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle Moore control unit: fetch/decode/execute FSM driving the datapath
// strobes from the current state and the opcode captured during fetch.
`timescale 1ns/1ps
module mc_control_unit
  import mc_control_unit_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  mc_control_unit_if.master bus
);

  logic [3:0] state_reg;
  logic [3:0] state_next;
  logic [5:0] opcode_reg;
  logic [3:0] func_reg;
  dec_t       dec;

  logic       pc_sel;
  logic       pc_ld_en;
  logic       ir_ld_en;
  logic       rf_wr_en;
  logic       rf_wr_data_sel;
  logic       rf_b_sel;
  logic       alu_bin_sel;
  logic [3:0] alu_func;
  logic [1:0] imm_ext;
  logic       mem_wr_en;
  logic       byte_op;
  logic       illegal;
  logic       alu_hold;
  logic       unused_instr_bits;

  assign unused_instr_bits = ^bus.Instr[25:4];

  mc_decoder u_decoder (
    .opcode (opcode_reg),
    .dec    (dec)
  );

  // Opcode/func are captured on the same edge the IR loads, so S_DEC already
  // decodes from registered state and every output stays Moore.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg  <= S_IF1;
      opcode_reg <= '0;
      func_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_IF2) begin
        opcode_reg <= bus.Instr[31:26];
        func_reg   <= bus.Instr[3:0];
      end
    end
  end

  always_comb begin
    state_next = S_IF1;
    case (state_reg)
      S_IF1: state_next = S_IF2;
      S_IF2: state_next = S_DEC;
      S_DEC: begin
        case (dec.cls)
          CLS_ALU_R:  state_next = S_EXR;
          CLS_ALU_I:  state_next = S_EXI;
          CLS_BRANCH: state_next = S_BR;
          CLS_LOAD,
          CLS_STORE:  state_next = S_MADDR;
          default:    state_next = S_WBALU;
        endcase
      end
      S_EXR, S_EXI: state_next = S_WBALU;
      S_MADDR:      state_next = (dec.cls == CLS_LOAD) ? S_MRD : S_MWR;
      S_MRD:        state_next = S_WBMEM;
      default:      state_next = S_IF1;
    endcase
  end

  // ALU operand setup stays applied through memory and write-back states so the
  // combinational ALU result (address or write data) is stable while consumed.
  always_comb begin
    alu_hold = (state_reg == S_EXR)   || (state_reg == S_EXI)   ||
               (state_reg == S_MADDR) || (state_reg == S_MRD)   ||
               (state_reg == S_MWR)   || (state_reg == S_WBALU) ||
               (state_reg == S_WBMEM);
  end

  always_comb begin
    pc_sel         = 1'b0;
    pc_ld_en       = 1'b0;
    ir_ld_en       = 1'b0;
    rf_wr_en       = 1'b0;
    rf_wr_data_sel = 1'b0;
    rf_b_sel       = 1'b0;
    alu_bin_sel    = 1'b0;
    alu_func       = ALU_ADD;
    imm_ext        = IMM_ZEXT;
    mem_wr_en      = 1'b0;
    byte_op        = 1'b0;
    illegal        = 1'b0;

    if (alu_hold) begin
      if (dec.cls == CLS_ALU_R) begin
        alu_func = func_reg;
      end else if (dec.cls != CLS_ILLEGAL) begin
        alu_func    = dec.alu_func;
        imm_ext     = dec.imm_ext;
        alu_bin_sel = 1'b1;
      end
    end

    case (state_reg)
      S_IF2: ir_ld_en = 1'b1;
      S_DEC: illegal  = dec.illegal;
      S_BR: begin
        rf_b_sel = 1'b1;
        alu_func = ALU_SUB;
        imm_ext  = IMM_SEXT_SL2;
        pc_ld_en = 1'b1;
        pc_sel   = branch_taken(dec.br, bus.Zero);
      end
      S_MRD: byte_op = dec.byte_op;
      S_MWR: begin
        rf_b_sel  = 1'b1;
        mem_wr_en = 1'b1;
        byte_op   = dec.byte_op;
        pc_ld_en  = 1'b1;
      end
      S_WBALU: begin
        rf_wr_en = ~dec.illegal;
        pc_ld_en = 1'b1;
      end
      S_WBMEM: begin
        rf_wr_en       = 1'b1;
        rf_wr_data_sel = 1'b1;
        byte_op        = dec.byte_op;
        pc_ld_en       = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset masks every strobe in the cycle it is sampled, so an interrupted
  // store or write-back never commits.
  assign bus.PC_Sel        = pc_sel & ~Reset;
  assign bus.PC_LdEn       = pc_ld_en & ~Reset;
  assign bus.IR_LdEn       = ir_ld_en & ~Reset;
  assign bus.RF_WrEn       = rf_wr_en & ~Reset;
  assign bus.RF_WrData_sel = rf_wr_data_sel & ~Reset;
  assign bus.RF_B_sel      = rf_b_sel & ~Reset;
  assign bus.ALU_Bin_sel   = alu_bin_sel & ~Reset;
  assign bus.ALU_func      = Reset ? 4'b0000 : alu_func;
  assign bus.ImmExt        = Reset ? 2'b00 : imm_ext;
  assign bus.MEM_WrEn      = mem_wr_en & ~Reset;
  assign bus.ByteOp        = byte_op & ~Reset;
  assign bus.Illegal       = illegal & ~Reset;

`ifndef SYNTHESIS
  a_wr_exclusive: assert property (@(posedge Clk) !(bus.RF_WrEn && bus.MEM_WrEn));
  a_pc_ld_single: assert property (@(posedge Clk) disable iff (Reset)
                                   bus.PC_LdEn |=> !bus.PC_LdEn);
`endif

endmodule

// File: doc/mc_control_unit.md
MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

Interface
REQ-001 Clk  input  1  system clock; all state updates on rising edge.
REQ-002 Reset  input  1  reset; synchronous, active-high.
REQ-003 Instr  input  32  current instruction word (IMEM dout); opcode = Instr[31:26], ALU func = Instr[3:0].
REQ-004 Zero  input  1  ALU zero flag, combinational from the current ALU operation.
REQ-005 PC_Sel  output  1  next-PC select: 0 = PC+4, 1 = PC+4+PC_Immed.
REQ-006 PC_LdEn  output  1  PC load enable for instruction_fetch.
REQ-007 IR_LdEn  output  1  instruction register load enable.
REQ-008 RF_WrEn  output  1  register file write enable.
REQ-009 RF_WrData_sel  output  1  write-back source: 0 = ALU, 1 = MEM.
REQ-010 RF_B_sel  output  1  second read address: 0 = rt field, 1 = rd field.
REQ-011 ALU_Bin_sel  output  1  ALU B operand: 0 = register, 1 = immediate.
REQ-012 ALU_func  output  4  ALU operation code.
REQ-013 ImmExt  output  2  immediate mode: 00 = zero-ext, 01 = sign-ext, 10 = <<16, 11 = sign-ext<<2.
REQ-014 MEM_WrEn  output  1  data memory write enable.
REQ-015 ByteOp  output  1  1 = byte access (lb/sb), 0 = word.
REQ-016 Illegal  output  1  one-cycle pulse when the decoded opcode is undefined.

Function
REQ-017 Moore FSM; all outputs SHALL be pure functions of state plus the latched opcode, except PC_Sel in S_BR, which also depends on Zero.
REQ-018 States: S_IF1, S_IF2, S_DEC, S_EXR, S_EXI, S_BR, S_MADDR, S_MRD, S_MWR, S_WBALU, S_WBMEM.
REQ-019 S_IF1: all outputs 0; covers the 1-cycle synchronous IMEM read latency. Next state S_IF2.
REQ-020 S_IF2: IR_LdEn=1. Next state S_DEC.
REQ-021 S_DEC: opcode latched internally; dispatch as follows:
- R-type (100000) -> S_EXR
- li 111000 / lui 111001 / addi 110000 / andi 110010 / ori 110011 -> S_EXI
- b 111111 / beq 000000 / bne 000001 -> S_BR
- lb 000011 / lw 001111 / sb 000111 / sw 011111 -> S_MADDR
- any other opcode -> S_WBALU with RF_WrEn=0 and Illegal=1 for the S_DEC cycle (treated as NOP).
REQ-022 S_EXR: ALU_func=Instr[3:0], ALU_Bin_sel=0. Next state S_WBALU.
REQ-023 S_EXI: ALU_Bin_sel=1.
- ALU_func: ADD for li/lui/addi, AND for andi, OR for ori.
- ImmExt: 01 for li/addi, 10 for lui, 00 for andi/ori.
- li/lui rely on rs=r0 by encoding.
- Next state S_WBALU.
REQ-024 S_BR: RF_B_sel=1, ALU_func=SUB, ImmExt=11, PC_LdEn=1.
- PC_Sel = b | (beq & Zero) | (bne & ~Zero).
- Next state S_IF1.
REQ-025 S_MADDR: ALU_Bin_sel=1, ALU_func=ADD, ImmExt=01. Next state S_MRD for loads, S_MWR for stores.
REQ-026 S_MRD: ByteOp per opcode; memory read cycle. Next state S_WBMEM.
REQ-027 S_MWR: RF_B_sel=1, MEM_WrEn=1, ByteOp per opcode, PC_LdEn=1, PC_Sel=0. Next state S_IF1.
REQ-028 S_WBALU: RF_WrEn=1 (0 for an illegal NOP), RF_WrData_sel=0, PC_LdEn=1, PC_Sel=0. Next state S_IF1.
REQ-029 S_WBMEM: RF_WrEn=1, RF_WrData_sel=1, ByteOp held, PC_LdEn=1, PC_Sel=0. Next state S_IF1.
REQ-030 Instruction latencies, from S_IF1 to the PC_LdEn cycle inclusive: branch 4, ALU 5, store 5, load 6, illegal 4.
REQ-031 PC_LdEn SHALL be asserted for exactly one cycle per instruction.
REQ-032 MEM_WrEn and RF_WrEn SHALL never be asserted in the same cycle.

Reset
REQ-033 Reset sampled high at any edge, including mid-instruction, SHALL force state S_IF1 and clear the latched opcode; no partial write or PC load may complete.
REQ-034 While in S_IF1 after reset, all outputs SHALL be 0; Reset has priority over every transition.

Structure
REQ-035 Shared package SHALL hold opcode constants, ALU_func codes, ImmExt codes and the state encoding (4-bit).
REQ-036 Opcode classification SHALL be a combinational sub-module mc_decoder (opcode -> class, ALU_func, ImmExt, ByteOp, Illegal); FSM and output logic live in mc_control_unit.

Verification
REQ-037 Reset mid-S_MWR of sw -> MEM_WrEn stays 0 in that cycle; next cycle state S_IF1 with all outputs 0.
REQ-038 R-type add (op 100000, func 0000) -> IR_LdEn in cycle 2; RF_WrEn=1 and PC_LdEn=1 in cycle 5; PC_Sel=0.
REQ-039 beq with Zero=1 -> PC_Sel=1, PC_LdEn=1 in cycle 4; with Zero=0 -> PC_Sel=0; bne gives the inverse.
REQ-040 lw -> S_MRD in cycle 5; cycle 6 has RF_WrEn=1, RF_WrData_sel=1, ByteOp=0; lb gives the same with ByteOp=1.
REQ-041 Opcode 101010 -> Illegal=1 for one cycle; no RF_WrEn or MEM_WrEn; PC_LdEn with PC_Sel=0 in cycle 4.
REQ-042 Back-to-back run of 100 random legal instructions -> exactly one PC_LdEn per instruction, and no cycle with both RF_WrEn and MEM_WrEn.
